ifetch_unit: RTL and testbench



---
 rtl/ifetch_pkg.sv | 10 +
 rtl/ifetch_unit_fetch_queue.sv | 29 ++
 rtl/ifetch_unit.sv | 54 +++++
 tb/tb_ifetch_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and the fetch queue entry type
package ifetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// fetch_queue: two-entry fifo of fetch entries whose head register drives the outputs directly
module fetch_queue
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t tail;
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop && count == 2'd2) head <= tail;
      else if (push && (count == 2'd0 || (pop && count == 2'd1))) head <= din;
      if (push && ((count == 2'd1 && !pop) || count == 2'd2)) tail <= din;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: pc-driven instruction fetch into a two-entry queue feeding decode over valid/ready
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] addr,
  input  logic [31:0] data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * INSTR_BYTES);
  if (QDEPTH != 2) begin : g_qdepth_check
    $error("ifetch_unit supports QDEPTH == 2 only");
  end
  logic [31:0]  pc;
  logic [1:0]   count;
  logic         push, pop, fault;
  fetch_entry_t din, head;
  assign addr      = pc;
  assign fault     = pc >= MEM_BYTES;
  assign pop       = out_valid & out_ready;
  assign push      = fetch_en & ~redirect_valid & (count != 2'd2 | pop);
  assign din       = '{pc: pc, instr: fault ? NOP_INSTR : data, fault: fault};
  assign out_valid = count != 2'd0;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_fault = head.fault;
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & ~32'd3;
    else if (push) pc <= pc + 32'(INSTR_BYTES);
  end
  fetch_queue u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed and scoreboarded checks of ifetch_unit against a tb-side imem model
module tb_ifetch_unit;
  logic        clk = 1'b0, reset = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] addr, data, out_pc, out_instr;
  logic        out_valid, out_fault;
  logic [31:0] mem [256];
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign data = (addr < 32'd1024) ? mem[addr[9:2]] : 32'hDEAD_BEEF;
  ifetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .addr           (addr),
    .data           (data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );
  function automatic logic [64:0] exp_of(input logic [31:0] p);
    exp_of = (p < 32'd1024) ? {p, 32'h1000_0000 + {24'd0, p[9:2]}, 1'b0} : {p, 32'h0000_0013, 1'b1};
  endfunction
  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_pc, out_instr, out_fault} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_pc, out_instr, out_fault});
    end
    n_cmp++;
    if (addr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_addr got=%h exp=0", addr);
    end
  endtask
  task automatic test_stream();
    reset = 1'b0;
    n_cmp++;
    if ({out_valid, addr} !== 33'd0) begin
      n_err++;
      $display("FAIL stream_start got=%h exp=0", {out_valid, addr});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_pc, out_instr, out_fault, addr} !== {1'b1, exp_of(32'(4 * i)), 32'(4 * i + 4)}) begin
        n_err++;
        $display("FAIL stream_%0d got=%h exp=%h", i, {out_valid, out_pc, out_instr, out_fault, addr},
                 {1'b1, exp_of(32'(4 * i)), 32'(4 * i + 4)});
      end
    end
  endtask
  task automatic test_stall();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_pc, out_instr, out_fault, addr} !== {1'b1, exp_of(32'd20), 32'd28}) begin
        n_err++;
        $display("FAIL stall_%0d got=%h exp=%h", k, {out_valid, out_pc, out_instr, out_fault, addr},
                 {1'b1, exp_of(32'd20), 32'd28});
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_pc, out_instr, out_fault, addr} !== {1'b1, exp_of(32'(24 + 4 * k)), 32'(32 + 4 * k)}) begin
        n_err++;
        $display("FAIL resume_%0d got=%h exp=%h", k, {out_valid, out_pc, out_instr, out_fault, addr},
                 {1'b1, exp_of(32'(24 + 4 * k)), 32'(32 + 4 * k)});
      end
    end
  endtask
  task automatic test_redirect(input logic [31:0] rpc, input logic [31:0] start, input int n, input logic ready);
    out_ready = ready; redirect_valid = 1'b1; redirect_pc = rpc;
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if ({out_valid, addr} !== {1'b0, start}) begin
      n_err++;
      $display("FAIL redirect_%h_flush got=%h exp=%h", rpc, {out_valid, addr}, {1'b0, start});
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_pc, out_instr, out_fault, addr} !== {1'b1, exp_of(start + 32'(4 * k)), start + 32'(4 * k + 4)}) begin
        n_err++;
        $display("FAIL redirect_%h_%0d got=%h exp=%h", rpc, k, {out_valid, out_pc, out_instr, out_fault, addr},
                 {1'b1, exp_of(start + 32'(4 * k)), start + 32'(4 * k + 4)});
      end
    end
  endtask
  task automatic test_reset_mid();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0;
    n_cmp++;
    if ({out_valid, addr} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_mid got=%h exp=0", {out_valid, addr});
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_pc, out_instr, out_fault, addr} !== {1'b1, exp_of(32'd0), 32'd4}) begin
      n_err++;
      $display("FAIL reset_mid_restart got=%h exp=%h", {out_valid, out_pc, out_instr, out_fault, addr},
               {1'b1, exp_of(32'd0), 32'd4});
    end
  endtask
  task automatic test_random();
    logic [31:0] exp_pc = 32'd0;
    int hs = 0;
    for (int c = 0; c < 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      fetch_en  = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({out_pc, out_instr, out_fault} !== exp_of(exp_pc)) begin
          n_err++;
          $display("FAIL random_hs_%0d got=%h exp=%h", hs, {out_pc, out_instr, out_fault}, exp_of(exp_pc));
        end
        exp_pc += 32'd4;
        hs++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (hs < 100) begin
      n_err++;
      $display("FAIL random_handshakes got=%0d exp=>=100", hs);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect(32'h0000_0043, 32'h0000_0040, 4, 1'b0);
    test_redirect(32'h0000_03F8, 32'h0000_03F8, 3, 1'b1);
    test_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, 1'b1);
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
